// File: rtl/im_port_arbiter.sv
// Arbitrates the single-port instruction memory between CPU fetch and the loader/debug
// write port; the loader wins ties but may only take MAX_LD_BURST grants in a row while fetch waits.
module im_port_arbiter #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_3000,
  parameter int          DEPTH_WORDS  = 2048,
  parameter int          MAX_LD_BURST = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_if_req,
  input  logic [31:0]                    i_if_pc,
  output logic                           o_if_stall,
  output logic                           o_if_valid,
  output logic [31:0]                    o_if_instr,
  output logic                           o_if_fault,
  input  logic                           i_ld_req,
  input  logic [31:0]                    i_ld_addr,
  input  logic [31:0]                    i_ld_wdata,
  output logic                           o_ld_ack,
  output logic                           o_ld_err,
  output logic [$clog2(DEPTH_WORDS)-1:0] o_mem_addr,
  output logic                           o_mem_we,
  output logic [31:0]                    o_mem_wdata,
  input  logic [31:0]                    i_mem_rdata
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT   = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  MAX_CNT = 4'(MAX_LD_BURST);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD} state_t;

  state_t          r_state, w_state_next;
  logic [3:0]      r_ld_cnt, w_ld_cnt_next;
  logic            w_gnt_fetch, w_gnt_ld;
  logic [31:0]     w_if_off, w_ld_off;
  logic            w_if_ok, w_ld_ok;
  logic [AW-1:0]   w_if_idx, w_ld_idx;
  logic            r_if_valid, r_if_fault, r_ld_ack, r_ld_err;
  logic [31:0]     r_if_instr;

  // Offsets wrap, so addresses just below BASE_ADDR land far out of range.
  assign w_if_off = i_if_pc - BASE_ADDR;
  assign w_ld_off = i_ld_addr - BASE_ADDR;
  assign w_if_ok  = (i_if_pc[1:0] == 2'b00) && (w_if_off < LIMIT);
  assign w_ld_ok  = (i_ld_addr[1:0] == 2'b00) && (w_ld_off < LIMIT);
  assign w_if_idx = w_if_off[AW+1:2];
  assign w_ld_idx = w_ld_off[AW+1:2];

  always_comb begin
    w_gnt_fetch   = 1'b0;
    w_gnt_ld      = 1'b0;
    w_state_next  = S_IDLE;
    w_ld_cnt_next = r_ld_cnt;

    if (i_ld_req && i_if_req && (r_ld_cnt == MAX_CNT)) begin
      w_gnt_fetch = 1'b1;
    end else if (i_ld_req) begin
      w_gnt_ld = 1'b1;
    end else if (i_if_req) begin
      w_gnt_fetch = 1'b1;
    end

    if (w_gnt_ld) begin
      w_state_next = S_LOAD;
    end else if (w_gnt_fetch) begin
      w_state_next = S_FETCH;
    end

    // A loader run only counts while fetch is actually waiting behind it.
    if (!i_if_req || w_gnt_fetch) begin
      w_ld_cnt_next = 4'd0;
    end else if (w_gnt_ld) begin
      if (r_state != S_LOAD) begin
        w_ld_cnt_next = 4'd1;
      end else if (r_ld_cnt != MAX_CNT) begin
        w_ld_cnt_next = r_ld_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_ld_cnt   <= 4'd0;
      r_if_valid <= 1'b0;
      r_if_fault <= 1'b0;
      r_if_instr <= 32'd0;
      r_ld_ack   <= 1'b0;
      r_ld_err   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ld_cnt   <= w_ld_cnt_next;
      r_if_valid <= w_gnt_fetch;
      r_if_fault <= w_gnt_fetch && !w_if_ok;
      if (w_gnt_fetch) begin
        r_if_instr <= w_if_ok ? i_mem_rdata : 32'd0;
      end
      r_ld_ack   <= w_gnt_ld;
      r_ld_err   <= w_gnt_ld && !w_ld_ok;
    end
  end

  // Write enable is gated by reset directly so no stray write slips in while reset is low.
  assign o_mem_we    = w_gnt_ld && w_ld_ok && i_rst_n;
  assign o_mem_addr  = w_gnt_ld ? w_ld_idx : (w_gnt_fetch ? w_if_idx : '0);
  assign o_mem_wdata = w_gnt_ld ? i_ld_wdata : 32'd0;
  assign o_if_stall  = i_if_req && !w_gnt_fetch;

  assign o_if_valid  = r_if_valid;
  assign o_if_fault  = r_if_fault;
  assign o_if_instr  = r_if_instr;
  assign o_ld_ack    = r_ld_ack;
  assign o_ld_err    = r_ld_err;

endmodule

// File: tb/tb_im_port_arbiter.sv
// Bench for im_port_arbiter: drivers push expected responses into queues, a negedge monitor
// pops and compares them against a word-level reference memory kept by the bench.
module tb_im_port_arbiter;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam int          DEPTH = 2048;
  localparam int          MAXB  = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } ldOp_t;

  logic        clk;
  logic        rstN;
  logic        ifReq, ifStall, ifValid, ifFault;
  logic [31:0] ifPc, ifInstr;
  logic        ldReq, ldAck, ldErr;
  logic [31:0] ldAddr, ldWdata;
  logic [10:0] memAddr;
  logic        memWe;
  logic [31:0] memWdata, memRdata;

  logic [31:0] im     [DEPTH];
  logic [31:0] refMem [DEPTH];
  logic [31:0] fetchQ [$];
  ldOp_t       ldQ    [$];
  int          vectors     = 0;
  int          miscompares = 0;

  im_port_arbiter #(
    .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .MAX_LD_BURST(MAXB)
  ) dut (
    .i_clk(clk), .i_rst_n(rstN),
    .i_if_req(ifReq), .i_if_pc(ifPc), .o_if_stall(ifStall),
    .o_if_valid(ifValid), .o_if_instr(ifInstr), .o_if_fault(ifFault),
    .i_ld_req(ldReq), .i_ld_addr(ldAddr), .i_ld_wdata(ldWdata),
    .o_ld_ack(ldAck), .o_ld_err(ldErr),
    .o_mem_addr(memAddr), .o_mem_we(memWe), .o_mem_wdata(memWdata),
    .i_mem_rdata(memRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Initial memory contents, shared by the bench IM and the reference memory.
  function automatic logic [31:0] seedWord(input int i);
    if (i == 0) return 32'h2408_0001;
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit addrOk(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a % 4 == 0) && (off < 32'(DEPTH * 4));
  endfunction

  function automatic logic [10:0] idxOf(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return 11'(off / 4);
  endfunction

  function automatic logic [31:0] randValidAddr();
    return BASE + 32'(4 * $urandom_range(0, 15));
  endfunction

  // Mostly a small hot region so reads hit earlier writes, plus edges and garbage.
  function automatic logic [31:0] randAnyAddr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 6) return randValidAddr();
    if (sel == 6) return BASE + 32'(4 * (DEPTH - 1));
    if (sel == 7) return BASE + 32'(4 * DEPTH);
    if (sel == 8) return BASE - 32'd4;
    return $urandom;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory: combinational read, write on the rising edge.
  initial begin
    for (int i = 0; i < DEPTH; i++) im[i] = seedWord(i);
    forever begin
      @(posedge clk);
      if (memWe) im[memAddr] <= memWdata;
    end
  end
  assign memRdata = im[memAddr];

  // Monitor: loader acks are retired first so a fetch issued right after a write sees it.
  initial begin
    ldOp_t       op;
    logic [31:0] pc;
    for (int i = 0; i < DEPTH; i++) refMem[i] = seedWord(i);
    forever begin
      @(negedge clk);
      if (ldAck) begin
        if (ldQ.size() == 0) begin
          checkOutput("ld_ack_unexpected", 32'(ldAck), 32'd0);
        end else begin
          op = ldQ.pop_front();
          checkOutput("ld_err", 32'(ldErr), 32'(!addrOk(op.addr)));
          if (addrOk(op.addr)) refMem[idxOf(op.addr)] = op.data;
        end
      end
      if (ifValid) begin
        if (fetchQ.size() == 0) begin
          checkOutput("if_valid_unexpected", 32'(ifValid), 32'd0);
        end else begin
          pc = fetchQ.pop_front();
          checkOutput("if_fault", 32'(ifFault), 32'(!addrOk(pc)));
          checkOutput("if_instr", ifInstr, addrOk(pc) ? refMem[idxOf(pc)] : 32'd0);
        end
      end
      if (memWe) begin
        checkOutput("mem_we_legal",
                    {28'd0, ldReq, addrOk(ldAddr), memAddr == idxOf(ldAddr), memWdata == ldWdata},
                    32'hF);
      end
    end
  end

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic applyFetch(input logic [31:0] pc, input bit directed);
    int lat;
    ifReq = 1'b1;
    ifPc  = pc;
    fetchQ.push_back(pc);
    if (directed) begin
      #1;
      checkOutput("fetch_stall_free", 32'(ifStall), 32'd0);
      checkOutput("fetch_no_we", 32'(memWe), 32'd0);
      if (addrOk(pc)) checkOutput("fetch_mem_addr", 32'(memAddr), 32'(idxOf(pc)));
    end
    lat = 0;
    do begin
      stepEdge();
      lat++;
    end while (!ifValid && lat < 4 * MAXB + 4);
    if (!ifValid) begin
      checkOutput("fetch_timeout", 32'(ifValid), 32'd1);
    end else if (directed) begin
      checkOutput("fetch_latency", 32'(lat), 32'd1);
    end else begin
      checkOutput("fetch_latency_bound", 32'(lat <= MAXB + 1), 32'd1);
    end
    ifReq = 1'b0;
  endtask

  task automatic applyLoad(input logic [31:0] addr, input logic [31:0] data, input bit directed);
    int    lat;
    ldOp_t op;
    op.addr = addr;
    op.data = data;
    ldReq   = 1'b1;
    ldAddr  = addr;
    ldWdata = data;
    ldQ.push_back(op);
    if (directed) begin
      #1;
      checkOutput("load_mem_we", 32'(memWe), 32'(addrOk(addr)));
      if (addrOk(addr)) checkOutput("load_mem_addr", 32'(memAddr), 32'(idxOf(addr)));
    end
    lat = 0;
    do begin
      stepEdge();
      lat++;
    end while (!ldAck && lat < 8);
    if (!ldAck) begin
      checkOutput("load_timeout", 32'(ldAck), 32'd1);
    end else if (directed) begin
      checkOutput("load_latency", 32'(lat), 32'd1);
    end else begin
      checkOutput("load_latency_bound", 32'(lat <= 2), 32'd1);
    end
    ldReq = 1'b0;
  endtask

  // Both ports request every cycle; the loader should win MAXB times, then fetch once.
  // Returns between edges of the last cycle with both requests still high.
  task automatic applyStimulus(input int n);
    int          run;
    bit          fetchWins;
    logic [31:0] curPc;
    ldOp_t       curLd;
    run = 0;
    for (int c = 0; c < n; c++) begin
      if (c == 0 || ifValid) curPc = randValidAddr();
      if (c == 0 || ldAck) begin
        curLd.addr = randValidAddr();
        curLd.data = $urandom;
      end
      ifReq   = 1'b1;
      ifPc    = curPc;
      ldReq   = 1'b1;
      ldAddr  = curLd.addr;
      ldWdata = curLd.data;
      fetchWins = (run == MAXB);
      if (fetchWins) begin
        fetchQ.push_back(curPc);
        run = 0;
      end else begin
        ldQ.push_back(curLd);
        run++;
      end
      #1;
      checkOutput("burst_stall", 32'(ifStall), 32'(!fetchWins));
      if (c < n - 1) stepEdge();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN    = 1'b0;
    ifReq   = 1'b0;
    ifPc    = 32'd0;
    ldReq   = 1'b1;
    ldAddr  = BASE;
    ldWdata = 32'hFFFF_FFFF;
    #12;
    checkOutput("reset_if_valid", 32'(ifValid), 32'd0);
    checkOutput("reset_if_fault", 32'(ifFault), 32'd0);
    checkOutput("reset_if_instr", ifInstr, 32'd0);
    checkOutput("reset_ld_ack", 32'(ldAck), 32'd0);
    checkOutput("reset_ld_err", 32'(ldErr), 32'd0);
    checkOutput("reset_mem_we", 32'(memWe), 32'd0);
    ldReq = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    stepEdge();

    $display("[TB] directed fetch / write-then-read");
    applyFetch(32'h0000_3000, 1'b1);
    applyLoad(32'h0000_3004, 32'hDEAD_BEEF, 1'b1);
    applyFetch(32'h0000_3004, 1'b1);
    stepEdge();

    $display("[TB] loader burst against continuous fetch");
    applyStimulus(10);
    stepEdge();
    ifReq = 1'b0;
    ldReq = 1'b0;
    repeat (2) stepEdge();

    $display("[TB] invalid and boundary addresses");
    applyFetch(32'h0000_2FFC, 1'b1);
    applyFetch(32'h0000_5000, 1'b1);
    applyFetch(32'h0000_3001, 1'b1);
    applyLoad(32'h0000_3002, 32'h1234_5678, 1'b1);
    applyLoad(32'h0000_4FFC, 32'hCAFE_F00D, 1'b1);
    applyFetch(32'h0000_4FFC, 1'b1);
    stepEdge();

    $display("[TB] async reset mid-burst");
    applyStimulus(3);
    @(negedge clk);
    #1;
    rstN = 1'b0;
    fetchQ.delete();
    ldQ.delete();
    #1;
    checkOutput("midreset_ld_ack", 32'(ldAck), 32'd0);
    checkOutput("midreset_if_valid", 32'(ifValid), 32'd0);
    checkOutput("midreset_mem_we", 32'(memWe), 32'd0);
    checkOutput("midreset_if_instr", ifInstr, 32'd0);
    stepEdge();
    rstN = 1'b1;
    applyStimulus(7);
    stepEdge();
    ifReq = 1'b0;
    ldReq = 1'b0;
    repeat (2) stepEdge();

    $display("[TB] randomized concurrent traffic");
    fork
      begin
        repeat (150) begin
          repeat ($urandom_range(0, 2)) stepEdge();
          applyFetch(randAnyAddr(), 1'b0);
        end
      end
      begin
        repeat (150) begin
          repeat ($urandom_range(0, 2)) stepEdge();
          applyLoad(randAnyAddr(), $urandom, 1'b0);
        end
      end
    join
    repeat (3) stepEdge();
    checkOutput("fetch_queue_drained", 32'(fetchQ.size()), 32'd0);
    checkOutput("load_queue_drained", 32'(ldQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/im_port_arbiter.md
Name: im_port_arbiter

Overview:
- Shares the single-port 8 KB instruction memory between the CPU fetch stage and a program-loader/debug write port.
- Each cycle it grants one requester, translates its 32-bit byte address into the 11-bit word index, and drives the memory.
- It returns registered responses one cycle later.
- Loader has priority, bounded by a burst limit so fetch cannot starve.

Parameters:
- BASE_ADDR, 32'h0000_3000, byte address of IM word 0.
- DEPTH_WORDS, 2048, IM size in words; index width is 11.
- MAX_LD_BURST, 4, consecutive loader grants allowed while fetch is pending; range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset.
- if_req  in  1  fetch request; held with if_pc stable until if_valid.
- if_pc  in  32  fetch byte address.
- if_stall  out  1  combinational: if_req & ~fetch_grant.
- if_valid  out  1  registered: fetch completed.
- if_instr  out  32  registered: fetched word; 0 when if_fault.
- if_fault  out  1  registered: fetch address out of range or misaligned.
- ld_req  in  1  loader write request; held stable until ld_ack.
- ld_addr  in  32  loader byte address.
- ld_wdata  in  32  loader write data.
- ld_ack  out  1  registered: loader op completed (one-cycle pulse).
- ld_err  out  1  registered: loader address invalid, write suppressed; valid with ld_ack.
- mem_addr  out  11  IM word index (combinational).
- mem_we  out  1  IM write enable (combinational); IM writes on clk rising edge.
- mem_wdata  out  32  IM write data.
- mem_rdata  in  32  IM combinational read data.

Behaviour:
- Reset (reset=0, async): if_valid, if_fault, ld_ack and ld_err are 0; if_instr is 0; the FSM is S_IDLE; ld_cnt is 0.
- mem_we is forced 0 while reset=0. IM contents are untouched.
- Requests in flight at reset are dropped; requesters re-present them after reset.
- Address check, per port: off = addr - BASE_ADDR (32-bit, wrapping).
  - Valid iff addr[1:0]==0 and off < DEPTH_WORDS*4.
  - Index = off[12:2].
  - addr = BASE_ADDR-4 wraps to a huge offset and is invalid.
- Grant (combinational), in order:
  - ld_req & if_req & ld_cnt==MAX_LD_BURST -> fetch.
  - Else ld_req -> loader.
  - Else if_req -> fetch.
  - Else none.
- FSM states: S_IDLE (no grant last cycle), S_FETCH, S_LOAD. The next state follows the grant; the state is only used for ld_cnt.
- ld_cnt:
  - +1 on a loader grant while if_req=1, saturating at MAX_LD_BURST.
  - Cleared on a fetch grant or any cycle with if_req=0.
- Fetch grant:
  - mem_addr = fetch index; mem_we=0.
  - Next edge: if_valid=1, if_instr=mem_rdata (or 0 and if_fault=1 if invalid).
- Loader grant:
  - mem_addr = loader index, mem_wdata = ld_wdata, mem_we = valid.
  - Next edge: ld_ack=1, ld_err = ~valid.
- No grant: mem_we=0, mem_addr=0.
- All response pulses last exactly one cycle. A requester may deassert in the ack cycle or present a new op in that cycle. A request still high in the ack cycle is a new request.
- Latency: 1 cycle when uncontended. Fetch worst case is MAX_LD_BURST+1 cycles.
- Write then read of the same word: a fetch granted the cycle after the write sees the new data.
- Simultaneous first requests: loader wins.

Test Plan:
- Reset, then if_req=1, if_pc=32'h3000, IM[0]=32'h2408_0001 -> next cycle if_valid=1, if_instr=32'h2408_0001, if_stall=0.
- ld_req write ld_addr=32'h3004, ld_wdata=32'hDEAD_BEEF -> ld_ack=1, ld_err=0. Then fetch 32'h3004 -> if_instr=32'hDEAD_BEEF.
- ld_req held for 10 writes with if_req=1 continuously (MAX_LD_BURST=4):
  - Grants are L,L,L,L,F,L,L,L,L,F.
  - if_stall=1 for 4 cycles before each fetch grant.
- Invalid addresses:
  - Fetch 32'h2FFC -> if_fault=1, if_instr=0.
  - Fetch 32'h5000 -> if_fault=1.
  - ld_addr=32'h3002 -> ld_ack=1, ld_err=1, mem_we never asserted.
- Boundary: fetch 32'h4FFC -> valid, mem_addr=11'h7FF.
- Async reset mid-burst: drop reset while ld_req=1 between edges -> outputs clear immediately, mem_we=0, ld_cnt=0. After release, the first contested grant goes to the loader.
